alu_arbiter: RTL

- Shares one combinational ALU (4-bit FUNC_* opcode, two signed 32-bit operands) between NUM_REQ requesters, e.g. the EX stage and an address/branch helper unit.
- Uses round-robin arbitration with valid/ready handshakes on the request side.
- The ALU result is captured into a single response register with a valid/ready handshake.
- Sits between the requesters and the ALU instance. It drives the ALU inputs and consumes its result.

---
 rtl/alu_arbiter_pkg.sv | 27 ++
 rtl/alu_arbiter_rr_pick.sv | 36 +++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants for alu_arbiter: ALU function codes, requester limits and the idle opcode.
package alu_arbiter_pkg;

  localparam int FUNC_W = 4;

  localparam logic [FUNC_W-1:0] FUNC_ADD  = 4'd0;
  localparam logic [FUNC_W-1:0] FUNC_SUB  = 4'd1;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 4'd2;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 4'd3;
  localparam logic [FUNC_W-1:0] FUNC_XOR  = 4'd4;
  localparam logic [FUNC_W-1:0] FUNC_SLL  = 4'd5;
  localparam logic [FUNC_W-1:0] FUNC_SRL  = 4'd6;
  localparam logic [FUNC_W-1:0] FUNC_ARS  = 4'd7;
  localparam logic [FUNC_W-1:0] FUNC_SLT  = 4'd8;
  localparam logic [FUNC_W-1:0] FUNC_SLTU = 4'd9;
  localparam logic [FUNC_W-1:0] FUNC_BEQ  = 4'd10;
  localparam logic [FUNC_W-1:0] FUNC_BNE  = 4'd11;
  localparam logic [FUNC_W-1:0] FUNC_BLT  = 4'd12;
  localparam logic [FUNC_W-1:0] FUNC_BGE  = 4'd13;

  localparam int ALU_ARB_MAX_REQ  = 4;
  localparam int ALU_ARB_DEF_ID_W = 1;

  // Opcode presented to the ALU on cycles with no accepted request.
  localparam logic [FUNC_W-1:0] FUNC_IDLE = FUNC_ADD;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first masked request after last_i, wrapping modulo NUM_REQ.
module alu_arbiter_rr_pick import alu_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = ALU_ARB_DEF_ID_W
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  input  logic [NUM_REQ-1:0] mask_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  logic [NUM_REQ-1:0] req_m;
  logic [ID_W-1:0]    cand;
  logic               found;

  assign req_m = req_i & mask_i;

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_i) + k) % NUM_REQ);
      if (!found && req_m[cand]) begin
        found          = 1'b1;
        grant_o[cand]  = 1'b1;
        grant_idx_o    = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters, with a single
// registered response. Define ALU_ARB_LOCK_EN to add the req_lock port and grant locking.
module alu_arbiter import alu_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = ALU_ARB_DEF_ID_W,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  input  logic [FUNC_W*NUM_REQ-1:0] req_op,
  input  logic [DATA_W*NUM_REQ-1:0] req_in_1,
  input  logic [DATA_W*NUM_REQ-1:0] req_in_2,
  output logic [FUNC_W-1:0]         alu_op,
  output logic [DATA_W-1:0]         alu_in_1,
  output logic [DATA_W-1:0]         alu_in_2,
  input  logic [DATA_W-1:0]         alu_result,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic                      rsp_ready
);

  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;

  logic               slot_free;
  logic               accept;
  logic               adv_last;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] lock_mask;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;

  // Gating with reset keeps req_ready low for the whole reset window, not just its edge.
  assign slot_free = !rsp_valid_q || rsp_ready;
  assign pick_req  = (reset && slot_free) ? req_valid : '0;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [ID_W-1:0] lock_id_q, lock_id_d;

  always_comb begin
    lock_mask = '1;
    if (lock_q) begin
      lock_mask            = '0;
      lock_mask[lock_id_q] = 1'b1;
    end
  end

  assign adv_last = !lock_q;

  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (lock_q) begin
      if (!req_valid[lock_id_q] || !req_lock[lock_id_q]) lock_d = 1'b0;
    end else if (accept && req_lock[grant_idx]) begin
      lock_d    = 1'b1;
      lock_id_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`else
  assign lock_mask = '1;
  assign adv_last  = 1'b1;
`endif

  alu_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) rr_pick (
    .req_i       (pick_req),
    .last_i      (last_grant_q),
    .mask_i      (lock_mask),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  always_comb begin
    alu_op   = FUNC_IDLE;
    alu_in_1 = '0;
    alu_in_2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_op   = req_op[i*FUNC_W +: FUNC_W];
        alu_in_1 = req_in_1[i*DATA_W +: DATA_W];
        alu_in_2 = req_in_2[i*DATA_W +: DATA_W];
      end
    end
  end

  // A new accept always overwrites the slot; a drain alone just clears valid.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = alu_result;
      if (adv_last) last_grant_d = grant_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples its
  // next-state value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
